count_scheduler: RTL and testbench

Time-multiplexes one shared WIDTH-bit incrementer across NCH independent counter channels. Requesters raise a per-channel request, and a round-robin arbiter grants one channel per cycle. The granted channel's count register advances by one through the shared incrementer. The block sits above the existing up-counter datapath and replaces NCH private counters with one adder plus a register bank.

---
 rtl/count_sched_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/count_scheduler.sv | 83 ++++++++
 tb/tb_count_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and default sizing for the time-multiplexed counter scheduler.
package count_sched_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_e;
  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned WIDTH_DEF = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] elig_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] win_o,
  output logic [PW-1:0]  ptr_nxt_o
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    win_o     = '0;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NCH; off++) begin
      idx = PW'((int'(ptr_i) + off) % NCH);
      if (!found && elig_i[idx]) begin
        found      = 1'b1;
        win_o[idx] = 1'b1;
        ptr_nxt_o  = PW'((int'(idx) + 1) % NCH);
      end
    end
  end
endmodule

// File: rtl/count_scheduler.sv
// NCH counters sharing one incrementer; a round-robin arbiter picks one channel per cycle.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NCH-1:0]          req,
  input  logic [NCH-1:0]          clear,
  input  logic [$clog2(NCH)-1:0]  rd_sel,
  output logic [WIDTH-1:0]        rd_count,
  output logic [NCH-1:0]          gnt,
  output logic [NCH-1:0]          wrap,
  output logic                    busy
);
  localparam int PW = $clog2(NCH);

  state_e                     state_q, state_d;
  logic [PW-1:0]              ptr_q, ptr_nxt;
  logic [NCH-1:0][WIDTH-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]             gnt_q, wrap_q;
  logic [NCH-1:0]             elig, arb_win, win;
  logic [WIDTH-1:0]           sel_cnt, inc;
  logic                       roll;

  // A channel being cleared this cycle must not win, so it never moves ptr.
  assign elig = req & ~clear;
  assign win  = en ? arb_win : '0;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .win_o     (arb_win),
    .ptr_nxt_o (ptr_nxt)
  );

  // One-hot AND-OR mux into the single shared incrementer.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NCH; i++)
      if (win[i]) sel_cnt = sel_cnt | cnt_q[i];
    inc  = sel_cnt + WIDTH'(1);
    roll = (|win) & (&sel_cnt);
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear[i])    cnt_d[i] = '0;
      else if (win[i]) cnt_d[i] = inc;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (!en)        state_d = STALL;
    else if (|elig) state_d = ACTIVE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= win;
      wrap_q  <= roll ? win : '0;
      if (|win) ptr_q <= ptr_nxt;
    end
  end

  assign gnt      = gnt_q;
  assign wrap     = wrap_q;
  assign busy     = (state_q == ACTIVE);
  assign rd_count = cnt_q[rd_sel];
endmodule

// File: tb/tb_count_scheduler.sv
// Scoreboarded bench: a behavioural model pushes expected outputs each edge, popped after the edge.
module tb_count_scheduler;
  localparam int NCH = 4;
  localparam int WIDTH = 4;

  typedef struct {
    logic [NCH-1:0]            gnt;
    logic [NCH-1:0]            wrap;
    logic                      busy;
    logic [NCH-1:0][WIDTH-1:0] cnt;
  } exp_t;

  logic                   clk = 0, reset = 1, en = 0;
  logic [NCH-1:0]         req = '0, clear = '0;
  logic [1:0]             rd_sel = '0;
  logic [WIDTH-1:0]       rd_count;
  logic [NCH-1:0]         gnt, wrap;
  logic                   busy;

  int n_chk = 0, n_pass = 0;
  exp_t q[$];
  logic [NCH-1:0][WIDTH-1:0] m_cnt;
  int m_ptr;

  count_scheduler #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .clear(clear),
    .rd_sel(rd_sel), .rd_count(rd_count), .gnt(gnt), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cnt = '0;
    m_ptr = 0;
  endtask

  // Advance model one edge using the inputs that were applied before it.
  task automatic model_edge();
    exp_t e;
    logic [NCH-1:0] elig;
    int k;
    elig = req & ~clear;
    k = -1;
    if (en)
      for (int off = 0; off < NCH; off++)
        if (k < 0 && elig[(m_ptr + off) % NCH]) k = (m_ptr + off) % NCH;
    e.gnt = '0; e.wrap = '0;
    for (int i = 0; i < NCH; i++) if (clear[i]) m_cnt[i] = '0;
    if (k >= 0) begin
      e.gnt[k] = 1'b1;
      if (m_cnt[k] == {WIDTH{1'b1}}) e.wrap[k] = 1'b1;
      m_cnt[k] = m_cnt[k] + 1'b1;
      m_ptr = (k + 1) % NCH;
    end
    e.busy = en && (elig != '0);
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    chk("gnt", gnt, e.gnt);
    chk("wrap", wrap, e.wrap);
    chk("busy", busy, e.busy);
    for (int i = 0; i < NCH; i++) begin
      rd_sel = i[1:0];
      #1;
      chk($sformatf("cnt%0d", i), rd_count, e.cnt[i]);
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_out();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_busy"}, busy, 0);
    for (int i = 0; i < NCH; i++) begin
      rd_sel = i[1:0];
      #0.1;
      chk($sformatf("%s_cnt%0d", tag, i), rd_count, 0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_zero("rst");
    reset = 0;
    en = 1;

    req = 4'b0001;              step(3);
    req = 4'b1111;              step(8);
    req = 4'b0000; clear = 4'b0100; step(1);
    clear = 4'b0000; req = 4'b0100; step(16);   // 15 grants then the wrap
    req = 4'b0000; clear = 4'b1111; step(1);
    clear = 4'b0000; req = 4'b0001; step(1);
    req = 4'b0011; en = 0;      step(3);
    en = 1;                     step(2);        // ch1 first, ptr preserved
    req = 4'b0000; clear = 4'b0010; step(1);
    clear = 4'b0000; req = 4'b0010; step(5);
    clear = 4'b0010;            step(1);        // clear beats request
    clear = 4'b0000;            step(1);

    for (int r = 0; r < 30; r++) begin
      req   = NCH'($urandom_range(0, 15));
      clear = ($urandom_range(0, 5) == 0) ? NCH'($urandom_range(0, 15)) : '0;
      en    = ($urandom_range(0, 4) != 0);
      step(1);
    end

    en = 1; clear = '0; req = 4'b1111;
    step(2);
    reset = 1;                  // mid-cycle, well before next rising edge
    #1;
    check_zero("async_rst");
    q.delete();
    model_reset();
    #1 reset = 0;
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
